control_unit_ls: RTL and testbench

- Hardwired Moore control sequencer that drives the CPU datapath's control inputs. It replaces the hand-stepped control stimulus used in the phase 2 benches.
- Runs instruction fetch, then sequences execution for a load/store/ALU subset of the Mini SRC ISA, one control step per clock.
- Sits directly upstream of the CPU datapath. It consumes the IR contents and produces every datapath control strobe.

---
 rtl/cpu_ctrl_pkg.sv | 76 +++++++
 rtl/cu_opdecode.sv | 44 ++++
 rtl/control_unit_ls.sv | 227 ++++++++++++++++++++++
 tb/tb_control_unit_ls.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the Mini SRC load/store/ALU control sequencer:
// state encoding, opcode values, IR field positions and instruction classes.
package cpu_ctrl_pkg;

  localparam int IR_WIDTH = 32;
  localparam int OP_WIDTH = 5;

  // IR field positions
  localparam int OP_MSB = 31;
  localparam int OP_LSB = 27;
  localparam int RA_MSB = 26;
  localparam int RA_LSB = 23;
  localparam int RB_MSB = 22;
  localparam int RB_LSB = 19;
  localparam int RC_MSB = 18;
  localparam int RC_LSB = 15;
  localparam int C_MSB  = 18;
  localparam int C_LSB  = 0;

  typedef enum logic [3:0] {
    ST_RST  = 4'd0,
    ST_T0   = 4'd1,
    ST_T1   = 4'd2,
    ST_T2   = 4'd3,
    ST_T3   = 4'd4,
    ST_T4   = 4'd5,
    ST_T5   = 4'd6,
    ST_T6   = 4'd7,
    ST_T7   = 4'd8,
    ST_IDLE = 4'd9,
    ST_HALT = 4'd10
  } state_e;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  typedef enum logic [2:0] {
    CLS_LD   = 3'd0,
    CLS_LDI  = 3'd1,
    CLS_ST   = 3'd2,
    CLS_ALU3 = 3'd3,
    CLS_ADDI = 3'd4,
    CLS_NOP  = 3'd5,
    CLS_HALT = 3'd6,
    CLS_ILL  = 3'd7
  } iclass_e;

  // Bit positions inside the one-hot ALU select vector
  localparam int ALU_ADD = 0;
  localparam int ALU_SUB = 1;
  localparam int ALU_AND = 2;
  localparam int ALU_OR  = 3;

  // True when state s is the final execution step of instruction class c.
  // HALT never reaches a boundary; it is diverted to the HALT state instead.
  function automatic logic isLastStep(input state_e s, input iclass_e c);
    logic last;
    last = 1'b0;
    case (c)
      CLS_LD, CLS_ST:              last = (s == ST_T7);
      CLS_LDI, CLS_ALU3, CLS_ADDI: last = (s == ST_T5);
      CLS_NOP, CLS_ILL:            last = (s == ST_T3);
      default:                     last = 1'b0;
    endcase
    return last;
  endfunction

endpackage

// File: rtl/cu_opdecode.sv
// Combinational opcode classifier: maps the IR opcode field to an instruction
// class and, for three-register ALU ops, the one-hot ALU select.
module cu_opdecode
  import cpu_ctrl_pkg::*;
#(
  parameter int OP_W = 5
) (
  input  logic [OP_W-1:0] opcode_i,
  output iclass_e         iClass_o,
  output logic [3:0]      aluOp_o
);

  // Anything not in the supported subset is classed illegal
  always_comb begin
    iClass_o = CLS_ILL;
    aluOp_o  = 4'b0000;
    case (opcode_i)
      OP_LD:   iClass_o = CLS_LD;
      OP_LDI:  iClass_o = CLS_LDI;
      OP_ST:   iClass_o = CLS_ST;
      OP_ADD: begin
        iClass_o         = CLS_ALU3;
        aluOp_o[ALU_ADD] = 1'b1;
      end
      OP_SUB: begin
        iClass_o         = CLS_ALU3;
        aluOp_o[ALU_SUB] = 1'b1;
      end
      OP_AND: begin
        iClass_o         = CLS_ALU3;
        aluOp_o[ALU_AND] = 1'b1;
      end
      OP_OR: begin
        iClass_o        = CLS_ALU3;
        aluOp_o[ALU_OR] = 1'b1;
      end
      OP_ADDI: iClass_o = CLS_ADDI;
      OP_NOP:  iClass_o = CLS_NOP;
      OP_HALT: iClass_o = CLS_HALT;
      default: iClass_o = CLS_ILL;
    endcase
  end

endmodule

// File: rtl/control_unit_ls.sv
// Hardwired Moore sequencer for the Mini SRC datapath: fetch plus ld/ldi/st/
// ALU/addi execution. Strobes are a pure decode of the state and IR opcode.
module control_unit_ls
  import cpu_ctrl_pkg::*;
#(
  parameter int IR_W            = 32,
  parameter int OP_W            = 5,
  parameter bit HALT_ON_ILLEGAL = 1'b0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [IR_W-1:0] IR,
  input  logic            stop,
  output logic            PCout,
  output logic            Zlowout,
  output logic            MDRout,
  output logic            Cout,
  output logic            Gra,
  output logic            Grb,
  output logic            Grc,
  output logic            Rin,
  output logic            Rout,
  output logic            BAout,
  output logic            PCin,
  output logic            IRin,
  output logic            Yin,
  output logic            Zin,
  output logic            MARin,
  output logic            MDRin,
  output logic            IncPC,
  output logic            Read,
  output logic            write_mem,
  output logic            ADD,
  output logic            SUB,
  output logic            AND,
  output logic            OR,
  output logic            CON_RESET,
  output logic            run,
  output logic            illegal
);

  state_e          state_q;
  state_e          state_d;
  state_e          boundary;
  iclass_e         iClass;
  logic [3:0]      aluOp;
  logic [OP_W-1:0] opcode;
  logic            unusedIrFields;

  assign opcode = IR[IR_W-1 -: OP_W];
  // Register and constant fields are consumed by the datapath, not here
  assign unusedIrFields = ^IR[IR_W-OP_W-1:0];

  cu_opdecode #(
    .OP_W(OP_W)
  ) uOpDecode (
    .opcode_i(opcode),
    .iClass_o(iClass),
    .aluOp_o (aluOp)
  );

  assign boundary = stop ? ST_IDLE : ST_T0;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RST:  state_d = ST_T0;
      ST_T0:   state_d = ST_T1;
      ST_T1:   state_d = ST_T2;
      ST_T2:   state_d = ST_T3;
      ST_T3: begin
        if (iClass == CLS_HALT)
          state_d = ST_HALT;
        else if (iClass == CLS_ILL && HALT_ON_ILLEGAL)
          state_d = ST_HALT;
        else if (isLastStep(state_q, iClass))
          state_d = boundary;
        else
          state_d = ST_T4;
      end
      ST_T4:   state_d = isLastStep(state_q, iClass) ? boundary : ST_T5;
      ST_T5:   state_d = isLastStep(state_q, iClass) ? boundary : ST_T6;
      ST_T6:   state_d = isLastStep(state_q, iClass) ? boundary : ST_T7;
      ST_T7:   state_d = boundary;
      ST_IDLE: state_d = stop ? ST_IDLE : ST_T0;
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_RST;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state_q <= ST_RST;
    else
      state_q <= state_d;
  end

  always_comb begin
    PCout     = 1'b0;
    Zlowout   = 1'b0;
    MDRout    = 1'b0;
    Cout      = 1'b0;
    Gra       = 1'b0;
    Grb       = 1'b0;
    Grc       = 1'b0;
    Rin       = 1'b0;
    Rout      = 1'b0;
    BAout     = 1'b0;
    PCin      = 1'b0;
    IRin      = 1'b0;
    Yin       = 1'b0;
    Zin       = 1'b0;
    MARin     = 1'b0;
    MDRin     = 1'b0;
    IncPC     = 1'b0;
    Read      = 1'b0;
    write_mem = 1'b0;
    ADD       = 1'b0;
    SUB       = 1'b0;
    AND       = 1'b0;
    OR        = 1'b0;
    CON_RESET = 1'b0;
    run       = 1'b0;
    illegal   = 1'b0;
    case (state_q)
      ST_RST: CON_RESET = 1'b1;
      ST_T0: begin
        run   = 1'b1;
        IncPC = 1'b1;
        PCin  = 1'b1;
        MARin = 1'b1;
      end
      ST_T1: begin
        run   = 1'b1;
        Read  = 1'b1;
        MDRin = 1'b1;
      end
      ST_T2: begin
        run    = 1'b1;
        MDRout = 1'b1;
        IRin   = 1'b1;
      end
      ST_T3: begin
        run = 1'b1;
        case (iClass)
          CLS_LD, CLS_LDI, CLS_ST: begin
            Grb   = 1'b1;
            BAout = 1'b1;
            Yin   = 1'b1;
          end
          CLS_ALU3, CLS_ADDI: begin
            Grb  = 1'b1;
            Rout = 1'b1;
            Yin  = 1'b1;
          end
          CLS_ILL: illegal = 1'b1;
          default: ;
        endcase
      end
      ST_T4: begin
        run = 1'b1;
        case (iClass)
          CLS_LD, CLS_LDI, CLS_ST, CLS_ADDI: begin
            Cout = 1'b1;
            ADD  = 1'b1;
            Zin  = 1'b1;
          end
          CLS_ALU3: begin
            Grc  = 1'b1;
            Rout = 1'b1;
            Zin  = 1'b1;
            ADD  = aluOp[ALU_ADD];
            SUB  = aluOp[ALU_SUB];
            AND  = aluOp[ALU_AND];
            OR   = aluOp[ALU_OR];
          end
          default: ;
        endcase
      end
      ST_T5: begin
        run = 1'b1;
        case (iClass)
          CLS_LD, CLS_ST: begin
            Zlowout = 1'b1;
            MARin   = 1'b1;
          end
          CLS_LDI, CLS_ALU3, CLS_ADDI: begin
            Zlowout = 1'b1;
            Gra     = 1'b1;
            Rin     = 1'b1;
          end
          default: ;
        endcase
      end
      ST_T6: begin
        run = 1'b1;
        case (iClass)
          CLS_LD: begin
            Read  = 1'b1;
            MDRin = 1'b1;
          end
          // Read stays low so MDR captures the store data from the bus
          CLS_ST: begin
            Gra   = 1'b1;
            Rout  = 1'b1;
            MDRin = 1'b1;
          end
          default: ;
        endcase
      end
      ST_T7: begin
        run = 1'b1;
        case (iClass)
          CLS_LD: begin
            MDRout = 1'b1;
            Gra    = 1'b1;
            Rin    = 1'b1;
          end
          CLS_ST:  write_mem = 1'b1;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_unit_ls.sv
// Directed-vector bench for control_unit_ls; strobes are gathered into one
// vector per instance and compared against hand-computed masks.
module tb_control_unit_ls;

  localparam logic [25:0] S_PCOUT   = 26'd1 << 0;
  localparam logic [25:0] S_ZLOWOUT = 26'd1 << 1;
  localparam logic [25:0] S_MDROUT  = 26'd1 << 2;
  localparam logic [25:0] S_COUT    = 26'd1 << 3;
  localparam logic [25:0] S_GRA     = 26'd1 << 4;
  localparam logic [25:0] S_GRB     = 26'd1 << 5;
  localparam logic [25:0] S_GRC     = 26'd1 << 6;
  localparam logic [25:0] S_RIN     = 26'd1 << 7;
  localparam logic [25:0] S_ROUT    = 26'd1 << 8;
  localparam logic [25:0] S_BAOUT   = 26'd1 << 9;
  localparam logic [25:0] S_PCIN    = 26'd1 << 10;
  localparam logic [25:0] S_IRIN    = 26'd1 << 11;
  localparam logic [25:0] S_YIN     = 26'd1 << 12;
  localparam logic [25:0] S_ZIN     = 26'd1 << 13;
  localparam logic [25:0] S_MARIN   = 26'd1 << 14;
  localparam logic [25:0] S_MDRIN   = 26'd1 << 15;
  localparam logic [25:0] S_INCPC   = 26'd1 << 16;
  localparam logic [25:0] S_READ    = 26'd1 << 17;
  localparam logic [25:0] S_WRITE   = 26'd1 << 18;
  localparam logic [25:0] S_ADD     = 26'd1 << 19;
  localparam logic [25:0] S_SUB     = 26'd1 << 20;
  localparam logic [25:0] S_AND     = 26'd1 << 21;
  localparam logic [25:0] S_OR      = 26'd1 << 22;
  localparam logic [25:0] S_CONRST  = 26'd1 << 23;
  localparam logic [25:0] S_RUN     = 26'd1 << 24;
  localparam logic [25:0] S_ILL     = 26'd1 << 25;

  localparam logic [25:0] BUS_MASK = S_PCOUT | S_ZLOWOUT | S_MDROUT | S_COUT | S_ROUT | S_BAOUT;
  localparam logic [25:0] ALU_MASK = S_ADD | S_SUB | S_AND | S_OR;

  localparam logic [25:0] E_RST = S_CONRST;
  localparam logic [25:0] E_T0  = S_RUN | S_INCPC | S_PCIN | S_MARIN;
  localparam logic [25:0] E_T1  = S_RUN | S_READ | S_MDRIN;
  localparam logic [25:0] E_T2  = S_RUN | S_MDROUT | S_IRIN;
  localparam logic [25:0] E_BA3 = S_RUN | S_GRB | S_BAOUT | S_YIN;
  localparam logic [25:0] E_R3  = S_RUN | S_GRB | S_ROUT | S_YIN;
  localparam logic [25:0] E_C4  = S_RUN | S_COUT | S_ADD | S_ZIN;
  localparam logic [25:0] E_MA5 = S_RUN | S_ZLOWOUT | S_MARIN;
  localparam logic [25:0] E_WB5 = S_RUN | S_ZLOWOUT | S_GRA | S_RIN;
  localparam logic [25:0] E_LD6 = S_RUN | S_READ | S_MDRIN;
  localparam logic [25:0] E_LD7 = S_RUN | S_MDROUT | S_GRA | S_RIN;
  localparam logic [25:0] E_ST6 = S_RUN | S_GRA | S_ROUT | S_MDRIN;
  localparam logic [25:0] E_ST7 = S_RUN | S_WRITE;
  localparam logic [25:0] E_NOP = S_RUN;
  localparam logic [25:0] E_ILL = S_RUN | S_ILL;

  localparam logic [31:0] IR_LD   = 32'h00900054;
  localparam logic [31:0] IR_LDI  = 32'h08800005;
  localparam logic [31:0] IR_ST   = 32'h10880087;
  localparam logic [31:0] IR_ADD  = 32'h19A28000;
  localparam logic [31:0] IR_SUB  = 32'h21A28000;
  localparam logic [31:0] IR_ADDI = 32'h60900003;
  localparam logic [31:0] IR_NOP  = 32'hD0000000;
  localparam logic [31:0] IR_HALT = 32'hD8000000;
  localparam logic [31:0] IR_BAD  = 32'hF8000000;

  logic        clk;
  logic        reset;
  logic [31:0] IR;
  logic        stop;
  logic [25:0] ctl0;
  logic [25:0] ctl1;
  int          vectors;
  int          miscompares;

  control_unit_ls #(
    .HALT_ON_ILLEGAL(1'b0)
  ) dut0 (
    .clk(clk), .reset(reset), .IR(IR), .stop(stop),
    .PCout(ctl0[0]), .Zlowout(ctl0[1]), .MDRout(ctl0[2]), .Cout(ctl0[3]),
    .Gra(ctl0[4]), .Grb(ctl0[5]), .Grc(ctl0[6]), .Rin(ctl0[7]),
    .Rout(ctl0[8]), .BAout(ctl0[9]), .PCin(ctl0[10]), .IRin(ctl0[11]),
    .Yin(ctl0[12]), .Zin(ctl0[13]), .MARin(ctl0[14]), .MDRin(ctl0[15]),
    .IncPC(ctl0[16]), .Read(ctl0[17]), .write_mem(ctl0[18]), .ADD(ctl0[19]),
    .SUB(ctl0[20]), .AND(ctl0[21]), .OR(ctl0[22]), .CON_RESET(ctl0[23]),
    .run(ctl0[24]), .illegal(ctl0[25])
  );

  control_unit_ls #(
    .HALT_ON_ILLEGAL(1'b1)
  ) dut1 (
    .clk(clk), .reset(reset), .IR(IR), .stop(stop),
    .PCout(ctl1[0]), .Zlowout(ctl1[1]), .MDRout(ctl1[2]), .Cout(ctl1[3]),
    .Gra(ctl1[4]), .Grb(ctl1[5]), .Grc(ctl1[6]), .Rin(ctl1[7]),
    .Rout(ctl1[8]), .BAout(ctl1[9]), .PCin(ctl1[10]), .IRin(ctl1[11]),
    .Yin(ctl1[12]), .Zin(ctl1[13]), .MARin(ctl1[14]), .MDRin(ctl1[15]),
    .IncPC(ctl1[16]), .Read(ctl1[17]), .write_mem(ctl1[18]), .ADD(ctl1[19]),
    .SUB(ctl1[20]), .AND(ctl1[21]), .OR(ctl1[22]), .CON_RESET(ctl1[23]),
    .run(ctl1[24]), .illegal(ctl1[25])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%07h, expected 0x%07h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] ir, input logic stp);
    IR   = ir;
    stop = stp;
  endtask

  task automatic stepCheck(input string tag, input logic [25:0] expected);
    @(posedge clk);
    #1;
    checkOutput(tag, 32'(ctl0), 32'(expected));
  endtask

  task automatic fetchTail();
    stepCheck("fetchT1", E_T1);
    stepCheck("fetchT2", E_T2);
  endtask

  // Structural invariants sampled on every falling edge
  always @(negedge clk) begin
    if (!reset) begin
      checkOutput("busDrivers", 32'($countones(ctl0 & BUS_MASK) <= 1), 32'd1);
      checkOutput("readWrite", 32'(ctl0[17] & ctl0[18]), 32'd0);
      checkOutput("aluOneHot", 32'($countones(ctl0 & ALU_MASK) <= 1), 32'd1);
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    applyStimulus(IR_LD, 1'b0);
    #12;
    checkOutput("rst0", 32'(ctl0), 32'(E_RST));
    checkOutput("rst1", 32'(ctl1), 32'(E_RST));
    @(negedge clk);
    reset = 1'b0;

    // ld: 8 steps then back to T0
    stepCheck("ldT0", E_T0);
    fetchTail();
    stepCheck("ldT3", E_BA3);
    stepCheck("ldT4", E_C4);
    stepCheck("ldT5", E_MA5);
    stepCheck("ldT6", E_LD6);
    stepCheck("ldT7", E_LD7);
    stepCheck("ldNextT0", E_T0);

    // second ld, reset asserted in the middle of T6
    fetchTail();
    stepCheck("ld2T3", E_BA3);
    stepCheck("ld2T4", E_C4);
    stepCheck("ld2T5", E_MA5);
    stepCheck("ld2T6", E_LD6);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("rstMidT6", 32'(ctl0), 32'(E_RST));
    @(negedge clk);
    reset = 1'b0;
    stepCheck("rstT0", E_T0);

    // st
    applyStimulus(IR_ST, 1'b0);
    fetchTail();
    stepCheck("stT3", E_BA3);
    stepCheck("stT4", E_C4);
    stepCheck("stT5", E_MA5);
    stepCheck("stT6", E_ST6);
    stepCheck("stT7", E_ST7);
    stepCheck("stNextT0", E_T0);

    // add and sub
    applyStimulus(IR_ADD, 1'b0);
    fetchTail();
    stepCheck("addT3", E_R3);
    stepCheck("addT4", S_RUN | S_GRC | S_ROUT | S_ADD | S_ZIN);
    stepCheck("addT5", E_WB5);
    stepCheck("addNextT0", E_T0);
    applyStimulus(IR_SUB, 1'b0);
    fetchTail();
    stepCheck("subT3", E_R3);
    stepCheck("subT4", S_RUN | S_GRC | S_ROUT | S_SUB | S_ZIN);
    stepCheck("subT5", E_WB5);
    stepCheck("subNextT0", E_T0);

    // addi
    applyStimulus(IR_ADDI, 1'b0);
    fetchTail();
    stepCheck("addiT3", E_R3);
    stepCheck("addiT4", E_C4);
    stepCheck("addiT5", E_WB5);
    stepCheck("addiNextT0", E_T0);

    // ldi with stop held: parks in IDLE until stop drops
    applyStimulus(IR_LDI, 1'b1);
    fetchTail();
    stepCheck("ldiT3", E_BA3);
    stepCheck("ldiT4", E_C4);
    stepCheck("ldiT5", E_WB5);
    for (int i = 0; i < 3; i++) stepCheck("idleHold", 26'd0);
    applyStimulus(IR_NOP, 1'b0);
    stepCheck("idleExitT0", E_T0);

    // nop
    fetchTail();
    stepCheck("nopT3", E_NOP);
    stepCheck("nopNextT0", E_T0);

    // illegal opcode on both instances
    applyStimulus(IR_BAD, 1'b0);
    fetchTail();
    @(posedge clk);
    #1;
    checkOutput("illT3_h0", 32'(ctl0), 32'(E_ILL));
    checkOutput("illT3_h1", 32'(ctl1), 32'(E_ILL));
    @(posedge clk);
    #1;
    checkOutput("illNext_h0", 32'(ctl0), 32'(E_T0));
    checkOutput("illNext_h1", 32'(ctl1), 32'd0);
    applyStimulus(IR_HALT, 1'b0);
    @(posedge clk);
    #1;
    checkOutput("illAfter_h0", 32'(ctl0), 32'(E_T1));
    checkOutput("illAfter_h1", 32'(ctl1), 32'd0);

    // halt is absorbing
    stepCheck("haltT2", E_T2);
    stepCheck("haltT3", E_NOP);
    for (int i = 0; i < 20; i++) stepCheck("haltHold", 26'd0);

    #2;
    reset = 1'b1;
    #1;
    checkOutput("rstFromHalt", 32'(ctl0), 32'(E_RST));
    @(negedge clk);
    reset = 1'b0;
    stepCheck("haltRstT0", E_T0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
